// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed 7-segment scan controller with frame-aligned loads; HEXSCAN_BLINK_EN adds blinking
module hex_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 2
`ifdef HEXSCAN_BLINK_EN
    , parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    output logic                  READY,
    input  logic                  BLANK_LZ,
    output logic [3:0]            NUM,
    output logic                  ENABLED,
    output logic [DIGITS-1:0]     nDIG,
    output logic                  FRAME
`ifdef HEXSCAN_BLINK_EN
    , input  logic                BLINK
`endif
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DIGITS);
    logic [PW-1:0]         p;
    logic [DW-1:0]         d;
    logic [4*DIGITS-1:0]   disp, pend;
    logic                  pending;
    logic [DIGITS-1:0]     nz;
    logic                  blanked, blink_off, p_end, frame_end, accept, dark;
`ifdef HEXSCAN_BLINK_EN
    localparam int FW = $clog2(2 * BLINK_FRAMES);
    logic [FW-1:0]         f;
`endif
    assign p_end     = p == PW'(SCAN_DIV - 1);
    assign frame_end = p_end && d == DW'(DIGITS - 1);
    assign accept    = LOAD && READY;
    assign dark      = p < PW'(GUARD) || blink_off;
    // per-digit nonzero flags drive leading-zero blanking; blink darkens whole frames
    always_comb begin
        nz = '0;
        for (int i = 0; i < DIGITS; i++) nz[i] = |disp[4*i +: 4];
        blanked = BLANK_LZ && d != '0 && ~|(nz >> d);
`ifdef HEXSCAN_BLINK_EN
        blink_off = BLINK && f >= FW'(BLINK_FRAMES);
`else
        blink_off = 1'b0;
`endif
    end
    // scan counters, load handshake with frame-end apply, and registered display outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            p       <= '0;
            d       <= '0;
            disp    <= '0;
            pend    <= '0;
            pending <= 1'b0;
            READY   <= 1'b1;
            FRAME   <= 1'b0;
            NUM     <= '0;
            ENABLED <= 1'b0;
            nDIG    <= '1;
`ifdef HEXSCAN_BLINK_EN
            f       <= '0;
`endif
        end else begin
            p     <= p_end ? '0 : p + 1'b1;
            d     <= p_end ? (d == DW'(DIGITS - 1) ? '0 : d + 1'b1) : d;
            FRAME <= frame_end;
            if (frame_end && pending) begin
                disp    <= pend;
                pending <= 1'b0;
            end else if (accept) begin
                pend    <= VALUE;
                pending <= 1'b1;
            end
            // READY returns one cycle after the apply so it stays low through the FRAME cycle
            READY <= accept ? 1'b0 : !pending;
            if (dark) begin
                nDIG    <= '1;
                ENABLED <= 1'b0;
            end else begin
                NUM     <= disp[4*d +: 4];
                nDIG    <= blanked ? '1 : ~(DIGITS'(1) << d);
                ENABLED <= !blanked;
            end
`ifdef HEXSCAN_BLINK_EN
            if (frame_end) f <= f == FW'(2 * BLINK_FRAMES - 1) ? '0 : f + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed bench for hex_scan_ctrl with DIGITS=4, SCAN_DIV=8, GUARD=2
module tb_hex_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        ready;
    logic        blank_lz = 1'b0;
    logic [3:0]  num;
    logic        enabled;
    logic [3:0]  ndig;
    logic        frame_o;
    int          total = 0;
    int          bad = 0;
`ifdef HEXSCAN_BLINK_EN
    logic        blink = 1'b0;
`endif

    hex_scan_ctrl #(
        .DIGITS(4), .SCAN_DIV(8), .GUARD(2)
`ifdef HEXSCAN_BLINK_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (
        .CLK(clk), .RST(rst), .VALUE(value), .LOAD(load), .READY(ready),
        .BLANK_LZ(blank_lz), .NUM(num), .ENABLED(enabled), .nDIG(ndig), .FRAME(frame_o)
`ifdef HEXSCAN_BLINK_EN
        , .BLINK(blink)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one 32-cycle frame: v is the shown value, en the lit-digit mask, optional loads at slots la/lb
    task automatic frame(input logic [15:0] v, input logic [3:0] en, input logic rdy1,
                         input int la, input logic [15:0] va, input int lb, input logic [15:0] vb);
        logic [3:0] sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int j = 1; j <= 32; j++) begin
            int k, s;
            tick();
            k = (j - 1) / 8;
            s = (j - 1) % 8;
            if (s < 2) begin
                chk("guard_ndig", ndig, 4'hF);
                chk("guard_en", enabled, 1'b0);
            end else if (s == 2 || s == 7) begin
                if (en[k]) begin
                    chk("drive_ndig", ndig, sel[k]);
                    chk("drive_num", num, v[4*k +: 4]);
                    chk("drive_en", enabled, 1'b1);
                end else begin
                    chk("blank_ndig", ndig, 4'hF);
                    chk("blank_en", enabled, 1'b0);
                end
            end
            if (j == 1) chk("ready_start", ready, rdy1);
            if (j == 31) chk("frame_low", frame_o, 1'b0);
            if (j == 32) chk("frame_pulse", frame_o, 1'b1);
            if ((la > 0 && j == la + 1) || (lb > 0 && j == lb + 1)) begin
                load = 1'b0;
                chk("ready_after_load", ready, 1'b0);
            end
            if (j == la) begin load = 1'b1; value = va; end
            if (j == lb) begin load = 1'b1; value = vb; end
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ndig", ndig, 4'hF);
        chk("rst_en", enabled, 1'b0);
        chk("rst_num", num, 4'h0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_frame", frame_o, 1'b0);
        rst = 1'b0;
        frame(16'h0000, 4'b1111, 1'b1, 5, 16'h12AB, 10, 16'hFFFF);
        chk("ready_in_frame_cycle", ready, 1'b0);
        frame(16'h12AB, 4'b1111, 1'b1, 31, 16'h0001, 0, 16'h0);
        frame(16'h12AB, 4'b1111, 1'b0, 0, 16'h0, 0, 16'h0);
        frame(16'h0001, 4'b1111, 1'b1, 5, 16'h0050, 0, 16'h0);
        blank_lz = 1'b1;
        frame(16'h0050, 4'b0011, 1'b1, 5, 16'h0000, 0, 16'h0);
        frame(16'h0000, 4'b0001, 1'b1, 0, 16'h0, 0, 16'h0);
        blank_lz = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 4) load = 1'b0;
            if (j == 3) begin load = 1'b1; value = 16'h9999; end
        end
        chk("mid_ndig", ndig, 4'b1011);
        chk("mid_ready", ready, 1'b0);
        rst = 1'b1;
        tick();
        chk("rst2_ndig", ndig, 4'hF);
        chk("rst2_en", enabled, 1'b0);
        chk("rst2_num", num, 4'h0);
        chk("rst2_ready", ready, 1'b1);
        chk("rst2_frame", frame_o, 1'b0);
        rst = 1'b0;
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
`ifdef HEXSCAN_BLINK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        blink = 1'b1;
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
        frame(16'h0000, 4'b0000, 1'b1, 0, 16'h0, 0, 16'h0);
        frame(16'h0000, 4'b0000, 1'b1, 0, 16'h0, 0, 16'h0);
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
        blink = 1'b0;
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
        frame(16'h0000, 4'b1111, 1'b1, 0, 16'h0, 0, 16'h0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
